gpio_cfg_shift_bank: RTL and testbench

- Decodes the PS-driven GPIO configuration bus into committed, double-buffered configuration registers for the DAC/ADC control fabric.
- Synchronises the GPIO lines into the fabric clock and edge-detects each serial clock line. Shifts sdata into per-field shadow registers, then transfers all shadows to output registers atomically on a commit strobe.
- Generalises field widths and channel count; adds per-field length checking and single-cycle trigger/flush pulses.

---
 rtl/gpio_cfg_shift_bank_if.sv | 37 +++
 rtl/gpio_cfg_shift_bank.sv | 183 ++++++++++++++++++
 tb/tb_gpio_cfg_shift_bank.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_cfg_shift_bank_if.sv
// Bus bundle for gpio_cfg_shift_bank: raw PS GPIO in, committed configuration out.
// The master side drives gpio_in; the slave side is the decoder.
interface gpio_cfg_shift_bank_if #(
  parameter int GPIO_W  = 16,
  parameter int NUM_CH  = 16,
  parameter int CYCLE_W = 256,
  parameter int DELAY_W = 32,
  parameter int SHIFT_W = 8,
  parameter int MASK_W  = 16
);
  logic [GPIO_W-1:0]  gpio_in;
  logic [NUM_CH-1:0]  chan_sel;
  logic [CYCLE_W-1:0] cycle_count;
  logic [CYCLE_W-1:0] adc_cycles;
  logic [SHIFT_W-1:0] adc_shift;
  logic [DELAY_W-1:0] pre_delay;
  logic [DELAY_W-1:0] post_delay;
  logic [MASK_W-1:0]  mask;
  logic [NUM_CH-1:0]  mux_set;
  logic [NUM_CH-1:0]  mask_en;
  logic               pl_rst_out;
  logic               trig_pulse;
  logic               flush_pulse;
  logic [6:0]         len_err;
  logic               rdata;

  modport master (
    output gpio_in,
    input  chan_sel, cycle_count, adc_cycles, adc_shift, pre_delay, post_delay,
    input  mask, mux_set, mask_en, pl_rst_out, trig_pulse, flush_pulse, len_err, rdata
  );
  modport slave (
    input  gpio_in,
    output chan_sel, cycle_count, adc_cycles, adc_shift, pre_delay, post_delay,
    output mask, mux_set, mask_en, pl_rst_out, trig_pulse, flush_pulse, len_err, rdata
  );
endinterface

// File: rtl/gpio_cfg_shift_bank.sv
// Serial GPIO config decoder: synchronised clock lines shift sdata into shadows,
// a commit strobe copies them out atomically. CFG_READBACK_EN adds MSB readback on rdata.

// One multi-bit field: shadow shift register, saturating bit counter, committed copy.
module gpio_cfg_field #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_i,
  input  logic         sdata_i,
  input  logic         commit_i,
  output logic [W-1:0] shadow_o,
  output logic [W-1:0] val_o,
  output logic         err_o
);
  localparam int            CW      = $clog2(W + 2);
  localparam logic [CW-1:0] CNT_W   = CW'(W);
  localparam logic [CW-1:0] CNT_SAT = CW'(W + 1);

  logic [W-1:0]  shadow_q, shadow_d, val_q, val_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Commit sees the pre-shift shadow; a coincident shift restarts the count at 1.
  always_comb begin
    shadow_d = shadow_q;
    val_d    = val_q;
    cnt_d    = cnt_q;
    if (commit_i) begin
      if (cnt_q != '0) val_d = shadow_q;
      cnt_d = '0;
    end
    if (shift_i) begin
      shadow_d = {shadow_q[W-2:0], sdata_i};
      if (cnt_d != CNT_SAT) cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      val_q    <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      val_q    <= val_d;
      cnt_q    <= cnt_d;
    end
  end

  assign shadow_o = shadow_q;
  assign val_o    = val_q;
  assign err_o    = commit_i && (cnt_q != '0) && (cnt_q != CNT_W);
endmodule

module gpio_cfg_shift_bank #(
  parameter int GPIO_W  = 16,
  parameter int NUM_CH  = 16,
  parameter int CYCLE_W = 256,
  parameter int DELAY_W = 32,
  parameter int SHIFT_W = 8,
  parameter int MASK_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  gpio_cfg_shift_bank_if.slave bus
);
  logic [GPIO_W-1:0] s1_q, s2_q, s3_q, rise;
  logic              sdata, commit;
  logic [6:0]        shift, err, msb;
  logic [6:0]        len_err_q;
  logic [NUM_CH-1:0] mux_sh_q, mux_sh_d, men_sh_q, men_sh_d, mux_q, mux_d, men_q, men_d;
  logic              trig_q, flush_q;

  logic [NUM_CH-1:0]  sh_chan;
  logic [CYCLE_W-1:0] sh_cyc, sh_adc;
  logic [SHIFT_W-1:0] sh_shift;
  logic [DELAY_W-1:0] sh_pre, sh_post;
  logic [MASK_W-1:0]  sh_mask;
  logic               unused_bits;

  assign rise   = s2_q & ~s3_q;
  assign sdata  = s2_q[0];
  assign commit = rise[14];
  // Field order matches len_err bit order.
  assign shift  = {rise[1], rise[10], rise[9], rise[7], rise[8], rise[3], rise[2]};
  assign msb    = {sh_mask[MASK_W-1], sh_post[DELAY_W-1], sh_pre[DELAY_W-1],
                   sh_shift[SHIFT_W-1], sh_adc[CYCLE_W-1], sh_cyc[CYCLE_W-1], sh_chan[NUM_CH-1]};
  assign unused_bits = ^{rise, sh_cyc, sh_adc, sh_shift, sh_pre, sh_post, sh_mask};

  gpio_cfg_field #(.W(NUM_CH)) u_chan (
    .clk(clk), .rst(rst), .shift_i(shift[0]), .sdata_i(sdata), .commit_i(commit),
    .shadow_o(sh_chan), .val_o(bus.chan_sel), .err_o(err[0]));
  gpio_cfg_field #(.W(CYCLE_W)) u_cyc (
    .clk(clk), .rst(rst), .shift_i(shift[1]), .sdata_i(sdata), .commit_i(commit),
    .shadow_o(sh_cyc), .val_o(bus.cycle_count), .err_o(err[1]));
  gpio_cfg_field #(.W(CYCLE_W)) u_adc (
    .clk(clk), .rst(rst), .shift_i(shift[2]), .sdata_i(sdata), .commit_i(commit),
    .shadow_o(sh_adc), .val_o(bus.adc_cycles), .err_o(err[2]));
  gpio_cfg_field #(.W(SHIFT_W)) u_shift (
    .clk(clk), .rst(rst), .shift_i(shift[3]), .sdata_i(sdata), .commit_i(commit),
    .shadow_o(sh_shift), .val_o(bus.adc_shift), .err_o(err[3]));
  gpio_cfg_field #(.W(DELAY_W)) u_pre (
    .clk(clk), .rst(rst), .shift_i(shift[4]), .sdata_i(sdata), .commit_i(commit),
    .shadow_o(sh_pre), .val_o(bus.pre_delay), .err_o(err[4]));
  gpio_cfg_field #(.W(DELAY_W)) u_post (
    .clk(clk), .rst(rst), .shift_i(shift[5]), .sdata_i(sdata), .commit_i(commit),
    .shadow_o(sh_post), .val_o(bus.post_delay), .err_o(err[5]));
  gpio_cfg_field #(.W(MASK_W)) u_mask (
    .clk(clk), .rst(rst), .shift_i(shift[6]), .sdata_i(sdata), .commit_i(commit),
    .shadow_o(sh_mask), .val_o(bus.mask), .err_o(err[6]));

  // Per-channel fields write sdata into every channel selected by the chan_sel shadow.
  always_comb begin
    mux_sh_d = mux_sh_q;
    men_sh_d = men_sh_q;
    mux_d    = mux_q;
    men_d    = men_q;
    if (commit) begin
      mux_d = mux_sh_q;
      men_d = men_sh_q;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (sh_chan[i] && rise[4])  mux_sh_d[i] = sdata;
      if (sh_chan[i] && rise[12]) men_sh_d[i] = sdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      mux_sh_q  <= '0;
      men_sh_q  <= '0;
      mux_q     <= '0;
      men_q     <= '0;
      len_err_q <= '0;
      trig_q    <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      s1_q      <= bus.gpio_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      mux_sh_q  <= mux_sh_d;
      men_sh_q  <= men_sh_d;
      mux_q     <= mux_d;
      men_q     <= men_d;
      len_err_q <= len_err_q | err;
      trig_q    <= rise[6];
      flush_q   <= rise[13];
    end
  end

  assign bus.mux_set     = mux_q;
  assign bus.mask_en     = men_q;
  assign bus.len_err     = len_err_q;
  assign bus.trig_pulse  = trig_q;
  assign bus.flush_pulse = flush_q;
  assign bus.pl_rst_out  = s2_q[5];

`ifdef CFG_READBACK_EN
  logic rdata_q, rdata_d;

  // Descending scan so the lowest-numbered shifting field wins.
  always_comb begin
    rdata_d = rdata_q;
    for (int f = 6; f >= 0; f--)
      if (shift[f]) rdata_d = msb[f];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= 1'b0;
    else     rdata_q <= rdata_d;
  end

  assign bus.rdata = rdata_q;
`else
  logic unused_msb;
  assign unused_msb = ^msb;
  assign bus.rdata  = 1'b0;
`endif
endmodule

// File: tb/tb_gpio_cfg_shift_bank.sv
// Bench for gpio_cfg_shift_bank: table of serial transfers, corner sequences,
// then random GPIO traffic against a behavioural event model.
module tb_gpio_cfg_shift_bank;
  localparam int GPIO_W = 16, NUM_CH = 16, CYCLE_W = 256, DELAY_W = 32, SHIFT_W = 8, MASK_W = 16;
  localparam int NRAND = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [GPIO_W-1:0] g = '0;
  int nvec = 0, nerr = 0;

  gpio_cfg_shift_bank_if #(.GPIO_W(GPIO_W), .NUM_CH(NUM_CH), .CYCLE_W(CYCLE_W),
    .DELAY_W(DELAY_W), .SHIFT_W(SHIFT_W), .MASK_W(MASK_W)) bus ();
  assign bus.gpio_in = g;

  gpio_cfg_shift_bank #(.GPIO_W(GPIO_W), .NUM_CH(NUM_CH), .CYCLE_W(CYCLE_W),
    .DELAY_W(DELAY_W), .SHIFT_W(SHIFT_W), .MASK_W(MASK_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  // Field f in len_err order: width, clock line, DUT value.
  function automatic int fw(input int f);
    case (f)
      0: return NUM_CH;  1: return CYCLE_W; 2: return CYCLE_W; 3: return SHIFT_W;
      4: return DELAY_W; 5: return DELAY_W; default: return MASK_W;
    endcase
  endfunction
  function automatic int fcb(input int f);
    case (f)
      0: return 2; 1: return 3; 2: return 8; 3: return 7; 4: return 9; 5: return 10;
      default: return 1;
    endcase
  endfunction
  function automatic logic [255:0] fmask(input int f);
    logic [255:0] m;
    m = '1;
    return m >> (256 - fw(f));
  endfunction
  function automatic logic [255:0] dut_field(input int f);
    case (f)
      0: return 256'(bus.chan_sel);   1: return 256'(bus.cycle_count);
      2: return 256'(bus.adc_cycles); 3: return 256'(bus.adc_shift);
      4: return 256'(bus.pre_delay);  5: return 256'(bus.post_delay);
      default: return 256'(bus.mask);
    endcase
  endfunction

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [GPIO_W-1:0] v);
    @(posedge clk);
    #1 g = v;
  endtask

  task automatic send_bit(input int cb, input logic b);
    logic [GPIO_W-1:0] v;
    v = g; v[0] = b; v[cb] = 1'b0;
    step(v);
    v[cb] = 1'b1;
    step(v);
  endtask

  // MSB first, so the first bit ends up in the field's MSB.
  task automatic send_field(input int cb, input int n, input logic [255:0] data);
    for (int k = n - 1; k >= 0; k--) send_bit(cb, data[k]);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic commit_pulse();
    logic [GPIO_W-1:0] v;
    v = g; v[14] = 1'b1;
    step(v);
    v[14] = 1'b0;
    step(v);
    settle();
  endtask

  task automatic do_reset();
    g = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Behavioural model: one call per driven GPIO word, applying that word's rising edges.
  logic [255:0] m_sh[7], m_cv[7];
  int           m_cnt[7];
  logic [15:0]  m_mux_sh, m_men_sh, m_mux, m_men;
  logic [6:0]   m_err;
  logic         m_trig, m_flush, m_rd;

  typedef struct packed {
    logic [6:0][255:0] v;
    logic [15:0]       mux, men;
    logic [6:0]        err;
    logic              trig, flush, rd;
  } exp_t;

  task automatic model_clear();
    for (int f = 0; f < 7; f++) begin m_sh[f] = '0; m_cv[f] = '0; m_cnt[f] = 0; end
    m_mux_sh = '0; m_men_sh = '0; m_mux = '0; m_men = '0;
    m_err = '0; m_trig = 0; m_flush = 0; m_rd = 0;
  endtask

  function automatic exp_t model_snap();
    exp_t e;
    for (int f = 0; f < 7; f++) e.v[f] = m_cv[f];
    e.mux = m_mux; e.men = m_men; e.err = m_err;
    e.trig = m_trig; e.flush = m_flush; e.rd = m_rd;
    return e;
  endfunction

  task automatic model_step(input logic [15:0] cur, input logic [15:0] prev);
    logic [15:0]  r, old_ch;
    logic [255:0] old_sh[7];
    r = cur & ~prev;
    old_sh = m_sh;
    old_ch = m_sh[0][15:0];
    if (r[14]) begin
      for (int f = 0; f < 7; f++) begin
        if (m_cnt[f] != 0) begin
          m_cv[f] = m_sh[f];
          if (m_cnt[f] != fw(f)) m_err[f] = 1'b1;
        end
        m_cnt[f] = 0;
      end
      m_mux = m_mux_sh;
      m_men = m_men_sh;
    end
    for (int f = 0; f < 7; f++)
      if (r[fcb(f)]) begin
        m_sh[f] = ((old_sh[f] << 1) | 256'(cur[0])) & fmask(f);
        if (m_cnt[f] < fw(f) + 1) m_cnt[f]++;
      end
    for (int i = 0; i < 16; i++)
      if (old_ch[i]) begin
        if (r[4])  m_mux_sh[i] = cur[0];
        if (r[12]) m_men_sh[i] = cur[0];
      end
`ifdef CFG_READBACK_EN
    for (int f = 6; f >= 0; f--)
      if (r[fcb(f)]) m_rd = old_sh[f][fw(f)-1];
`endif
    m_trig  = r[6];
    m_flush = r[13];
  endtask

  typedef struct {
    string        nm;
    int           cb;
    int           nbits;
    logic [255:0] data;
    bit           cmt;
    int           f;
    logic [255:0] expv;
    logic [6:0]   experr;
  } vec_t;

  vec_t tbl[10];
  logic [255:0] pat256, pat100;
  exp_t eq[$];
  logic [15:0] plq[$];
  exp_t e;
  logic [15:0] pl_exp, prev, nxt;
  int pcnt, pat;

  initial begin
    pat256 = {4{64'h0123_4567_89AB_CDEF}};
    pat100 = 256'(100'hF_0123_4567_89AB_CDEF_0123_4567);
    tbl[0] = '{"chan_0005",    2, 16,  256'h0005,     1, 0, 256'h0005,     7'h00};
    tbl[1] = '{"pre_nocommit", 9, 32,  256'hDEADBEEF, 0, 4, 256'h0,        7'h00};
    tbl[2] = '{"pre_commit",   9, 0,   256'h0,        1, 4, 256'hDEADBEEF, 7'h00};
    tbl[3] = '{"shift_7bit",   7, 7,   256'h55,       1, 3, 256'h55,       7'h08};
    tbl[4] = '{"shift_8bit",   7, 8,   256'hA3,       1, 3, 256'hA3,       7'h08};
    tbl[5] = '{"mask_1234",    1, 16,  256'h1234,     1, 6, 256'h1234,     7'h08};
    tbl[6] = '{"post_delay",   10, 32, 256'h0BADF00D, 1, 5, 256'h0BADF00D, 7'h08};
    tbl[7] = '{"adc_cyc_256",  8, 256, pat256,        1, 2, pat256,        7'h08};
    tbl[8] = '{"cyc_100bit",   3, 100, pat100,        1, 1, pat100,        7'h0A};
    tbl[9] = '{"chan_8001",    2, 16,  256'h8001,     1, 0, 256'h8001,     7'h0A};

    do_reset();
    for (int f = 0; f < 7; f++) check($sformatf("reset_field%0d", f), dut_field(f), '0);
    check("reset_mux", 256'(bus.mux_set), '0);
    check("reset_len_err", 256'(bus.len_err), '0);
    check("reset_pulses", 256'({bus.trig_pulse, bus.flush_pulse, bus.pl_rst_out, bus.rdata}), '0);

    foreach (tbl[i]) begin
      send_field(tbl[i].cb, tbl[i].nbits, tbl[i].data);
      if (tbl[i].cmt) commit_pulse(); else settle();
      check(tbl[i].nm, dut_field(tbl[i].f), tbl[i].expv);
      check({tbl[i].nm, "_len_err"}, 256'(bus.len_err), 256'(tbl[i].experr));
    end

    // Channels 0 and 15 selected; one mux bit lands in both.
    send_bit(4, 1'b1);
    commit_pulse();
    check("mux_8001", 256'(bus.mux_set), 256'h8001);
    check("mask_en_zero", 256'(bus.mask_en), '0);
    check("chan_kept", 256'(bus.chan_sel), 256'h8001);

    // Held levels yield a single pulse three edges after the drive.
    foreach (tbl[i]) if (i < 2) begin
      int bitn;
      logic [GPIO_W-1:0] v;
      bitn = (i == 0) ? 6 : 13;
      v = g; v[bitn] = 1'b1;
      step(v);
      pcnt = 0; pat = -1;
      for (int c = 1; c <= 25; c++) begin
        @(posedge clk);
        @(negedge clk);
        if ((i == 0) ? bus.trig_pulse : bus.flush_pulse) begin pcnt++; pat = c; end
      end
      check($sformatf("pulse%0d_count", bitn), 256'(pcnt), 256'd1);
      check($sformatf("pulse%0d_cycle", bitn), 256'(pat), 256'd3);
      v = g; v[bitn] = 1'b0;
      step(v);
    end

    // Async reset mid-transfer wipes everything, including committed state.
    send_field(3, 100, {8{32'hC3A5_5A3C}});
    #2 rst = 1'b1;
    g = '0;
    #1;
    check("rst_async_chan", 256'(bus.chan_sel), '0);
    check("rst_async_len_err", 256'(bus.len_err), '0);
    check("rst_async_mux", 256'(bus.mux_set), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_bit(4, 1'b1);
    send_field(3, 256, '1);
    commit_pulse();
    check("cyc_all_ones", dut_field(1), '1);
    check("cyc_len_err", 256'(bus.len_err), '0);
    check("mux_no_chan", 256'(bus.mux_set), '0);

    // Random traffic: every output compared each cycle against the model.
    do_reset();
    model_clear();
    for (int i = 0; i < 3; i++) eq.push_back(model_snap());
    plq.push_back('0); plq.push_back('0);
    for (int n = 0; n < NRAND; n++) begin
      @(posedge clk);
      #1;
      prev = g;
      nxt = g;
      if ($urandom_range(0, 1) == 1) nxt[0] = 1'($urandom_range(0, 1));
      for (int b = 1; b < 16; b++) begin
        if (16'h179E >> b & 16'h1) begin
          if ($urandom_range(0, 2) == 0) nxt[b] = ~nxt[b];
        end else if (16'h2060 >> b & 16'h1) begin
          if ($urandom_range(0, 7) == 0) nxt[b] = ~nxt[b];
        end else if (b == 14) begin
          if ($urandom_range(0, 29) == 0) nxt[b] = ~nxt[b];
        end else nxt[b] = 1'($urandom_range(0, 1));
      end
      g = nxt;
      model_step(g, prev);
      eq.push_back(model_snap());
      plq.push_back(g);
      @(negedge clk);
      e = eq.pop_front();
      pl_exp = plq.pop_front();
      for (int f = 0; f < 7; f++) check($sformatf("rnd%0d_field%0d", n, f), dut_field(f), e.v[f]);
      check($sformatf("rnd%0d_mux", n), 256'(bus.mux_set), 256'(e.mux));
      check($sformatf("rnd%0d_mask_en", n), 256'(bus.mask_en), 256'(e.men));
      check($sformatf("rnd%0d_len_err", n), 256'(bus.len_err), 256'(e.err));
      check($sformatf("rnd%0d_trig", n), 256'(bus.trig_pulse), 256'(e.trig));
      check($sformatf("rnd%0d_flush", n), 256'(bus.flush_pulse), 256'(e.flush));
      check($sformatf("rnd%0d_rdata", n), 256'(bus.rdata), 256'(e.rd));
      check($sformatf("rnd%0d_pl_rst", n), 256'(bus.pl_rst_out), 256'(pl_exp[5]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
